tlc_phase_scheduler: RTL and testbench
======================================

# tlc_phase_scheduler

Four-way phase scheduler for the traffic-light controller. Latches vehicle requests from four approach sensors and grants green to one approach at a time, round-robin. Enforces minimum/maximum green, yellow and all-red clearance. Drives the four 3-bit LED groups directly.

## Interface
- MIN_GREEN, 5: minimum green duration, in ticks
- MAX_GREEN, 20: maximum green duration while another approach waits, in ticks
- YELLOW, 3: yellow duration, in ticks
- ALL_RED, 2: all-red clearance duration, in ticks
- TW, 8: timer width; must hold MAX_GREEN
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- tick  in  1  timebase enable; one-cycle pulse per time unit; timers advance only on tick cycles
- req  in  4  level sensor requests, [0]=North [1]=East [2]=South [3]=West
- preempt  in  1  emergency preemption request, level (TLC_PREEMPT_EN only)
- preempt_dir  in  2  approach to preempt to (TLC_PREEMPT_EN only)
- North_LEDs, East_LEDs, South_LEDs, West_LEDs  out  3 each  bit2=red, bit1=yellow, bit0=green; exactly one bit set
- grant  out  4  one-hot green approach; 0 when none is green
- active_dir  out  2  index of last granted approach (round-robin pointer)

## Operation
- States: IDLE (all red, nothing pending), GREEN, YELLOW, ALL_RED.
- Reset values:
  - state=ALL_RED, timer=0, pending=0, active_dir=3.
  - All LEDs 3'b100, grant=0.
- pending[i]:
  - Set on any clock where req[i]=1, unless approach i is currently GREEN.
  - Cleared on the edge where approach i enters GREEN.
  - A set and a clear on the same edge for different approaches both take effect.
- Timer:
  - Cleared on every state entry.
  - Increments on tick cycles; saturates at 2^TW-1.
- Transitions (evaluated only on tick cycles):
  - ALL_RED: when timer+1 == ALL_RED, pick the next pending approach and go to GREEN. If nothing is pending, go to IDLE.
  - IDLE: go to GREEN on the first tick with any pending.
  - GREEN: go to YELLOW when elapsed ≥ MIN_GREEN, another approach is pending, and either req[cur]=0 or elapsed ≥ MAX_GREEN.
  - GREEN with no other approach pending: rest in green indefinitely.
  - YELLOW: go to ALL_RED when timer+1 == YELLOW.
- Round-robin pick: search active_dir+1, +2, +3, +0 (mod 4); the first pending wins. active_dir updates to the winner.
- LED outputs are decoded from registered state and active_dir only; non-active approaches are red.

## Timing
- All state changes occur on the rising edge of a tick cycle. Outputs change on that same edge (no extra pipeline).
- A request latched on edge k is first eligible on the next tick edge after k.
- Phase lengths are exact, in ticks:
  - YELLOW ticks of yellow.
  - ALL_RED ticks of all-red.
  - Green lasts at least MIN_GREEN ticks.
  - Green lasts at most MAX_GREEN ticks while another approach waits.
- Reset asserted mid-phase: outputs go all red asynchronously; state and pending are cleared. After release, operation restarts in ALL_RED with a full clearance.
- tick=0 freezes timers and transitions. Request latching continues.
- Parameters with YELLOW=0 or ALL_RED=0 are illegal. Guard them with an elaboration-time check.

## Configuration
- TLC_PREEMPT_EN defined:
  - preempt and preempt_dir ports exist.
  - If preempt=1 and the current green ≠ preempt_dir, GREEN goes to YELLOW on the next tick, ignoring MIN_GREEN.
  - After ALL_RED, preempt_dir is granted directly, bypassing round-robin; active_dir=preempt_dir and pending[preempt_dir] is cleared.
  - While preempt=1 with its target green, that green is held regardless of MAX_GREEN.
- TLC_PREEMPT_EN undefined: ports absent; pure round-robin behaviour as above.

## Structure
- Shared package tlc_pkg:
  - state enum.
  - Direction indices N/E/S/W.
  - LED constants RED=3'b100, YEL=3'b010, GRN=3'b001.
- Sub-module tlc_rr_pick: combinational round-robin picker. Inputs are pending and active_dir; outputs are a valid bit and the winner index.

## Test plan
All scenarios use default parameters and tick=1 every cycle.
- Reset held, then released with req=0: LEDs all 3'b100 throughout, grant=0; state reaches IDLE after 2 ticks.
- Single-cycle pulse req=4'b0001 in IDLE: North_LEDs=3'b001 and grant=4'b0001 on the next tick edge; green is held indefinitely.
- North green with req[0]=0, req=4'b0010 pulsed at elapsed 1: North green for 5 ticks, yellow 3, all-red 2, then East_LEDs=3'b001.
- North green with req[0] held 1 and South pending: North stays green exactly 20 ticks, then goes yellow.
- From IDLE, req=4'b1111 for one cycle: grants in order N, E, S, W, each green for 5 ticks.
- Reset asserted during YELLOW: all LEDs 3'b100 before the next clock edge, pending=0. With TLC_PREEMPT_EN, a separate case: preempt=1, preempt_dir=2 at North green elapsed 1 → yellow on the next tick, then South green.

Source files
------------

// File: rtl/tlc_phase_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// tlc_pkg
// Shared definitions for the four-way traffic-light phase scheduler:
//   - tlc_state_e : scheduler phase encoding
//   - DIR_N/E/S/W : approach indices (bit positions in req/grant/pending)
//   - RED/YEL/GRN : one-hot LED group codes (bit2=red, bit1=yellow, bit0=green)
//   - dir_onehot(): approach index to one-hot approach mask
// -----------------------------------------------------------------------------
package tlc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2,
    ST_ALL_RED = 2'd3
  } tlc_state_e;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  function automatic logic [3:0] dir_onehot(input logic [1:0] dir);
    return 4'b0001 << dir;
  endfunction

endpackage

// File: rtl/tlc_phase_scheduler_if.sv
// -----------------------------------------------------------------------------
// tlc_phase_scheduler_if
// Signal bundle between the controller environment and the phase scheduler.
//   tick        : one-cycle timebase pulse
//   req[3:0]    : level vehicle sensors, [0]=N [1]=E [2]=S [3]=W
//   preempt     : emergency preemption level      (TLC_PREEMPT_EN only)
//   preempt_dir : approach to preempt to          (TLC_PREEMPT_EN only)
//   *_LEDs      : per-approach LED groups, {red, yellow, green}
//   grant       : one-hot green approach, 0 when none is green
//   active_dir  : round-robin pointer (last granted approach)
// Modports: master = environment/testbench, slave = scheduler.
// Optional feature macro: TLC_PREEMPT_EN.
// -----------------------------------------------------------------------------
interface tlc_phase_scheduler_if;

  logic       tick;
  logic [3:0] req;
`ifdef TLC_PREEMPT_EN
  logic       preempt;
  logic [1:0] preempt_dir;
`endif
  logic [2:0] North_LEDs;
  logic [2:0] East_LEDs;
  logic [2:0] South_LEDs;
  logic [2:0] West_LEDs;
  logic [3:0] grant;
  logic [1:0] active_dir;

`ifdef TLC_PREEMPT_EN
  modport master (
    output tick, req, preempt, preempt_dir,
    input  North_LEDs, East_LEDs, South_LEDs, West_LEDs, grant, active_dir
  );
  modport slave (
    input  tick, req, preempt, preempt_dir,
    output North_LEDs, East_LEDs, South_LEDs, West_LEDs, grant, active_dir
  );
`else
  modport master (
    output tick, req,
    input  North_LEDs, East_LEDs, South_LEDs, West_LEDs, grant, active_dir
  );
  modport slave (
    input  tick, req,
    output North_LEDs, East_LEDs, South_LEDs, West_LEDs, grant, active_dir
  );
`endif

endinterface

// File: rtl/tlc_phase_scheduler_rr_pick.sv
// -----------------------------------------------------------------------------
// tlc_rr_pick
// Combinational round-robin picker. Searches active_dir+1, +2, +3, +0 (mod 4)
// and reports the first pending approach.
//   i_pending[3:0]   : latched approach requests
//   i_active_dir[1:0]: last granted approach
//   o_valid          : some approach is pending
//   o_winner[1:0]    : winning approach (active_dir when none pending)
// -----------------------------------------------------------------------------
module tlc_rr_pick
  import tlc_pkg::*;
(
  input  logic [3:0] i_pending,
  input  logic [1:0] i_active_dir,
  output logic       o_valid,
  output logic [1:0] o_winner
);

  logic [1:0] w_idx;
  logic       w_hit;

  // First-pending search starting one past the last granted approach.
  always_comb begin
    o_valid  = 1'b0;
    o_winner = i_active_dir;
    w_idx    = i_active_dir;
    w_hit    = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      w_idx    = i_active_dir + 2'(k);
      w_hit    = !o_valid && i_pending[w_idx];
      o_winner = w_hit ? w_idx : o_winner;
      o_valid  = o_valid | w_hit;
    end
  end

endmodule

// File: rtl/tlc_phase_scheduler.sv
// -----------------------------------------------------------------------------
// tlc_phase_scheduler
// Four-way traffic-light phase scheduler. Latches approach requests, grants
// green to one approach at a time in round-robin order and sequences
// GREEN -> YELLOW -> ALL_RED, enforcing minimum/maximum green, yellow and
// all-red clearance times counted in ticks.
// Ports:
//   clk   : single clock, all state on rising edge
//   reset : asynchronous, active-high; forces all-red clearance state
//   bus   : tlc_phase_scheduler_if.slave (tick, req, LEDs, grant, active_dir,
//           and preempt/preempt_dir when TLC_PREEMPT_EN is defined)
// Optional feature macro: TLC_PREEMPT_EN (emergency preemption).
// -----------------------------------------------------------------------------
module tlc_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int unsigned MIN_GREEN = 5,
  parameter int unsigned MAX_GREEN = 20,
  parameter int unsigned YELLOW    = 3,
  parameter int unsigned ALL_RED   = 2,
  parameter int unsigned TW        = 8
)(
  input  logic                  clk,
  input  logic                  reset,
  tlc_phase_scheduler_if.slave  bus
);

  // Zero-length yellow/clearance would skip safety phases entirely.
  generate
    if (YELLOW == 0 || ALL_RED == 0) begin : g_bad_phase_len
      $fatal(1, "tlc_phase_scheduler: YELLOW and ALL_RED must be non-zero");
    end
    if (MAX_GREEN > ((2 ** TW) - 1)) begin : g_bad_timer_width
      $fatal(1, "tlc_phase_scheduler: TW too narrow for MAX_GREEN");
    end
  endgenerate

  localparam logic [TW:0]   L_MIN_GREEN = (TW+1)'(MIN_GREEN);
  localparam logic [TW:0]   L_MAX_GREEN = (TW+1)'(MAX_GREEN);
  localparam logic [TW:0]   L_YELLOW    = (TW+1)'(YELLOW);
  localparam logic [TW:0]   L_ALL_RED   = (TW+1)'(ALL_RED);
  localparam logic [TW-1:0] L_TIMER_MAX = {TW{1'b1}};

  tlc_state_e    r_state,      w_state_nxt;
  logic [TW-1:0] r_timer,      w_timer_nxt;
  logic [3:0]    r_pending,    w_pending_nxt;
  logic [1:0]    r_active_dir, w_active_dir_nxt;

  logic [TW:0]   w_elapsed;
  logic          w_pick_valid;
  logic [1:0]    w_pick_dir;
  logic          w_grant_valid;
  logic [1:0]    w_grant_dir;
  logic          w_enter_green;
  logic [3:0]    w_cur_green;
  logic          w_others_wait;
  logic          w_rr_yield;
  logic          w_go_yellow;
  logic [2:0]    w_leds [4];

  tlc_rr_pick u_rr_pick (
    .i_pending    (r_pending),
    .i_active_dir (r_active_dir),
    .o_valid      (w_pick_valid),
    .o_winner     (w_pick_dir)
  );

  // Elapsed counts the current tick, so "elapsed >= N" means N full ticks.
  assign w_elapsed     = {1'b0, r_timer} + {{TW{1'b0}}, 1'b1};
  assign w_cur_green   = (r_state == ST_GREEN) ? dir_onehot(r_active_dir) : 4'b0000;
  assign w_others_wait = |(r_pending & ~dir_onehot(r_active_dir));
  assign w_rr_yield    = (w_elapsed >= L_MIN_GREEN) && w_others_wait &&
                         (!bus.req[r_active_dir] || (w_elapsed >= L_MAX_GREEN));

`ifdef TLC_PREEMPT_EN
  // Preemption overrides round-robin choice and green-time limits.
  assign w_grant_valid = bus.preempt | w_pick_valid;
  assign w_grant_dir   = bus.preempt ? bus.preempt_dir : w_pick_dir;
  assign w_go_yellow   = (bus.preempt && (bus.preempt_dir != r_active_dir)) ||
                         (w_rr_yield && !bus.preempt);
`else
  assign w_grant_valid = w_pick_valid;
  assign w_grant_dir   = w_pick_dir;
  assign w_go_yellow   = w_rr_yield;
`endif

  // Next-state, next round-robin pointer and green-entry strobe.
  always_comb begin
    w_state_nxt      = r_state;
    w_active_dir_nxt = r_active_dir;
    w_enter_green    = 1'b0;
    if (bus.tick) begin
      case (r_state)
        ST_ALL_RED: begin
          if (w_elapsed == L_ALL_RED) begin
            if (w_grant_valid) begin
              w_state_nxt      = ST_GREEN;
              w_active_dir_nxt = w_grant_dir;
              w_enter_green    = 1'b1;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_state_nxt = ST_ALL_RED;
          end
        end
        ST_IDLE: begin
          if (w_grant_valid) begin
            w_state_nxt      = ST_GREEN;
            w_active_dir_nxt = w_grant_dir;
            w_enter_green    = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_GREEN: begin
          if (w_go_yellow) begin
            w_state_nxt = ST_YELLOW;
          end else begin
            w_state_nxt = ST_GREEN;
          end
        end
        ST_YELLOW: begin
          if (w_elapsed == L_YELLOW) begin
            w_state_nxt = ST_ALL_RED;
          end else begin
            w_state_nxt = ST_YELLOW;
          end
        end
        default: begin
          w_state_nxt = ST_ALL_RED;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Request latching: the approach entering green is cleared with priority.
  always_comb begin
    w_pending_nxt = r_pending | (bus.req & ~w_cur_green);
    if (w_enter_green) begin
      w_pending_nxt = w_pending_nxt & ~dir_onehot(w_active_dir_nxt);
    end else begin
      w_pending_nxt = w_pending_nxt;
    end
  end

  // Phase timer: restarts on every state change, saturates otherwise.
  always_comb begin
    w_timer_nxt = r_timer;
    if (w_state_nxt != r_state) begin
      w_timer_nxt = {TW{1'b0}};
    end else if (bus.tick && (r_timer != L_TIMER_MAX)) begin
      w_timer_nxt = r_timer + {{(TW-1){1'b0}}, 1'b1};
    end else begin
      w_timer_nxt = r_timer;
    end
  end

  // Scheduler state registers; reset lands in a full all-red clearance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_ALL_RED;
      r_timer      <= {TW{1'b0}};
      r_pending    <= 4'b0000;
      r_active_dir <= DIR_W;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_pending    <= w_pending_nxt;
      r_active_dir <= w_active_dir_nxt;
    end
  end

  // LED decode from registered state only; non-active approaches stay red.
  always_comb begin
    for (int d = 0; d < 4; d++) begin
      if ((r_state == ST_GREEN) && (r_active_dir == 2'(d))) begin
        w_leds[d] = GRN;
      end else if ((r_state == ST_YELLOW) && (r_active_dir == 2'(d))) begin
        w_leds[d] = YEL;
      end else begin
        w_leds[d] = RED;
      end
    end
  end

  assign bus.North_LEDs = w_leds[DIR_N];
  assign bus.East_LEDs  = w_leds[DIR_E];
  assign bus.South_LEDs = w_leds[DIR_S];
  assign bus.West_LEDs  = w_leds[DIR_W];
  assign bus.grant      = w_cur_green;
  assign bus.active_dir = r_active_dir;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tlc_phase_scheduler
// Scoreboard bench: each stimulus cycle advances a phase-level reference model
// and queues the outputs expected after the coming clock edge; an independent
// monitor pops and compares after every rising edge.
// -----------------------------------------------------------------------------
module tb_tlc_phase_scheduler;

  localparam int MIN_G = 5;
  localparam int MAX_G = 20;
  localparam int YEL_T = 3;
  localparam int CLR_T = 2;

  // Reference phases (own numbering, independent of the design).
  localparam int PH_REST  = 10;
  localparam int PH_GO    = 11;
  localparam int PH_AMBER = 12;
  localparam int PH_CLEAR = 13;

  typedef struct packed {
    logic [2:0] n;
    logic [2:0] e;
    logic [2:0] s;
    logic [2:0] w;
    logic [3:0] grant;
    logic [1:0] dir;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  int       m_phase;
  int       m_ticks;
  bit [3:0] m_pend;
  int       m_dir;

  tlc_phase_scheduler_if bus();

  tlc_phase_scheduler #(
    .MIN_GREEN (MIN_G),
    .MAX_GREEN (MAX_G),
    .YELLOW    (YEL_T),
    .ALL_RED   (CLR_T),
    .TW        (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_phase = PH_CLEAR;
    m_ticks = 0;
    m_pend  = 4'b0000;
    m_dir   = 3;
  endtask

  // Grant the first pending approach after the last one, or rest in red.
  task automatic model_grant(input bit [3:0] snap);
    bit found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      int c = (m_dir + k) % 4;
      if (!found && snap[c]) begin
        found     = 1'b1;
        m_dir     = c;
        m_pend[c] = 1'b0;
      end
    end
    m_phase = found ? PH_GO : PH_REST;
    m_ticks = 0;
  endtask

  task automatic model_step(input bit t, input bit [3:0] r);
    bit [3:0] snap = m_pend;
    for (int i = 0; i < 4; i++) begin
      if (r[i] && !(m_phase == PH_GO && m_dir == i)) m_pend[i] = 1'b1;
    end
    if (t) begin
      m_ticks++;
      if (m_phase == PH_CLEAR) begin
        if (m_ticks == CLR_T) model_grant(snap);
      end else if (m_phase == PH_REST) begin
        if (snap != 4'b0000) model_grant(snap);
      end else if (m_phase == PH_GO) begin
        bit [3:0] others = snap;
        others[m_dir] = 1'b0;
        if (m_ticks >= MIN_G && others != 4'b0000 && (!r[m_dir] || m_ticks >= MAX_G)) begin
          m_phase = PH_AMBER;
          m_ticks = 0;
        end
      end else if (m_phase == PH_AMBER) begin
        if (m_ticks == YEL_T) begin
          m_phase = PH_CLEAR;
          m_ticks = 0;
        end
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t x;
    logic [2:0] led [4];
    for (int d = 0; d < 4; d++) begin
      if (m_dir == d && m_phase == PH_GO)         led[d] = 3'b001;
      else if (m_dir == d && m_phase == PH_AMBER) led[d] = 3'b010;
      else                                        led[d] = 3'b100;
    end
    x.n     = led[0];
    x.e     = led[1];
    x.s     = led[2];
    x.w     = led[3];
    x.grant = (m_phase == PH_GO) ? (4'b0001 << m_dir) : 4'b0000;
    x.dir   = 2'(m_dir);
    return x;
  endfunction

  function automatic exp_t dut_out();
    exp_t x;
    x.n     = bus.North_LEDs;
    x.e     = bus.East_LEDs;
    x.s     = bus.South_LEDs;
    x.w     = bus.West_LEDs;
    x.grant = bus.grant;
    x.dir   = bus.active_dir;
    return x;
  endfunction

  // One stimulus cycle: drive inputs after the falling edge, queue expectation.
  task automatic cycle(input bit rst, input bit t, input bit [3:0] r);
    @(negedge clk);
    reset   = rst;
    bus.tick = t;
    bus.req  = r;
    if (rst) model_reset();
    else     model_step(t, r);
    exp_q.push_back(model_out());
  endtask

  // Monitor: compare DUT outputs after every rising edge with a queued entry.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = dut_out();
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs t=%0t got N=%b E=%b S=%b W=%b grant=%b dir=%0d exp N=%b E=%b S=%b W=%b grant=%b dir=%0d",
                   $time, a.n, a.e, a.s, a.w, a.grant, a.dir, e.n, e.e, e.s, e.w, e.grant, e.dir);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [3:0] sticky;
    bit       found;
    exp_t     a;
    exp_t     rst_exp;
    reset    = 1'b0;
    bus.tick = 1'b0;
    bus.req  = 4'b0000;
`ifdef TLC_PREEMPT_EN
    bus.preempt     = 1'b0;
    bus.preempt_dir = 2'd0;
`endif
    model_reset();
    rst_exp = model_out();
    #1 reset = 1'b1;
    #1;
    a = dut_out();
    n_tests++;
    if (a !== rst_exp) begin
      n_fail++;
      $display("FAIL reset_state got grant=%b dir=%0d N=%b exp grant=%b dir=%0d N=%b",
               a.grant, a.dir, a.n, rst_exp.grant, rst_exp.dir, rst_exp.n);
    end

    // Reset held, released with no requests: clearance then rest.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 4'b0000);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 4'b0000);
    // Single North pulse, held green, then East pulse.
    cycle(1'b0, 1'b1, 4'b0001);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 4'b0000);
    cycle(1'b0, 1'b1, 4'b0010);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 4'b0000);
    // All four at once from rest.
    cycle(1'b1, 1'b1, 4'b0000);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 4'b0000);
    cycle(1'b0, 1'b1, 4'b1111);
    for (int i = 0; i < 50; i++) cycle(1'b0, 1'b1, 4'b0000);
    // North held with South waiting: maximum green.
    cycle(1'b1, 1'b1, 4'b0000);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 4'b0000);
    cycle(1'b0, 1'b1, 4'b0001);
    cycle(1'b0, 1'b1, 4'b0101);
    for (int i = 0; i < 35; i++) cycle(1'b0, 1'b1, 4'b0001);

    // Random: sparse pulses with gapped ticks.
    for (int i = 0; i < 1500; i++)
      cycle(1'b0, ($urandom_range(0, 3) != 0), 4'(($urandom_range(0, 7) == 0) ? $urandom_range(1, 15) : 0));
    // Random: slowly toggling held sensors, tick every cycle.
    sticky = 4'b0000;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 23) == 0) sticky[b] = ~sticky[b];
      cycle(1'b0, 1'b1, sticky);
    end
    // Random: everything random.
    for (int i = 0; i < 800; i++)
      cycle(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));

    // Reset asserted mid-yellow: LEDs red before the next edge.
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      cycle(1'b0, 1'b1, 4'(($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0));
      @(posedge clk);
      #2;
      found = (m_phase == PH_AMBER);
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL yellow_reach got=not_reached exp=yellow");
    end else begin
      reset = 1'b1;
      #1;
      a = dut_out();
      model_reset();
      rst_exp = model_out();
      n_tests++;
      if (a !== rst_exp) begin
        n_fail++;
        $display("FAIL async_reset got N=%b E=%b S=%b W=%b grant=%b exp all 100 grant=0000",
                 a.n, a.e, a.s, a.w, a.grant);
      end
    end
    cycle(1'b1, 1'b1, 4'b0000);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 4'b0000);

    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
